// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - state type, widths and load-use hazard helper for pipe_ctrl
`include "header.vh"

package pipe_ctrl_pkg;

  localparam int ADDR_W  = `ADDR_WIDTH;
  localparam int VADDR_W = `VIRT_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_RUN      = `PCTL_RUN,
    ST_DC_WAIT  = `PCTL_DC_WAIT,
    ST_IC_WAIT  = `PCTL_IC_WAIT,
    ST_REDIRECT = `PCTL_REDIRECT
  } pctl_state_e;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  function automatic logic load_use_hazard(
    input logic              mem_r_en_ex,
    input logic [ADDR_W-1:0] reg_d_ex,
    input logic              use_a,
    input logic [ADDR_W-1:0] addr_a,
    input logic              use_b,
    input logic [ADDR_W-1:0] addr_b
  );
    return mem_r_en_ex && (reg_d_ex != '0) &&
           ((use_a && (addr_a == reg_d_ex)) || (use_b && (addr_b == reg_d_ex)));
  endfunction

endpackage

// File: rtl/header.vh
// rtl/header.vh - shared widths, FSM state encodings and NOP encoding for pipe_ctrl
`ifndef PIPE_CTRL_HEADER_VH
`define PIPE_CTRL_HEADER_VH

`define ADDR_WIDTH      5
`define VIRT_ADDR_WIDTH 32

`define PCTL_RUN      2'd0
`define PCTL_DC_WAIT  2'd1
`define PCTL_IC_WAIT  2'd2
`define PCTL_REDIRECT 2'd3

`define PCTL_NOP 32'h0000_0013

`endif

// File: rtl/pipe_ctrl_watchdog.sv
// rtl/pipe_ctrl_watchdog.sv - saturating blocked-cycle counter with sticky timeout flag
module pipe_stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic blocked,
  output logic stall_timeout
);

  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      stall_timeout <= 1'b0;
    end else if (blocked) begin
      if (count != LIMIT) count <= count + 1'b1;
      // This edge makes count reach LIMIT, so the flag rises together with it.
      if (count >= LIMIT - 1'b1) stall_timeout <= 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect scheduler; PIPE_PERF_CNT_EN adds perf counters
`include "header.vh"

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  addrA_d,
  input  logic [ADDR_W-1:0]  addrB_d,
  input  logic               useA_d,
  input  logic               useB_d,
  input  logic [ADDR_W-1:0]  regD_ex,
  input  logic               mem_r_en_ex,
  input  logic               branch_taken_ex,
  input  logic [VADDR_W-1:0] branch_target_ex,
  input  logic               block_pipe_data_cache,
  input  logic               block_pipe_instr_cache,
  output logic               en_pc,
  output logic               en_if_id,
  output logic               en_id_ex,
  output logic               en_ex_mem,
  output logic               en_mem_wb,
  output logic               flush_if_id,
  output logic               inject_nop_id_ex,
  output logic               pc_redirect,
  output logic [VADDR_W-1:0] pc_redirect_target,
  output logic [1:0]         state,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count,
`endif
  output logic               stall_timeout
);

  pctl_state_e        state_q, state_d;
  logic               pend, pend_set, pend_clr;
  logic [VADDR_W-1:0] pend_target;
  logic               lu;

  assign lu = load_use_hazard(mem_r_en_ex, regD_ex, useA_d, addrA_d, useB_d, addrB_d);
  assign state = state_q;

  always_comb begin
    en_pc              = 1'b1;
    en_if_id           = 1'b1;
    en_id_ex           = 1'b1;
    en_ex_mem          = 1'b1;
    en_mem_wb          = 1'b1;
    flush_if_id        = 1'b0;
    inject_nop_id_ex   = 1'b0;
    pc_redirect        = 1'b0;
    pc_redirect_target = '0;
    pend_set           = 1'b0;
    pend_clr           = 1'b0;
    if (!reset) begin
      {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
      flush_if_id      = 1'b1;
      inject_nop_id_ex = 1'b1;
    end else if (block_pipe_data_cache) begin
      // Branch stays held in the frozen ALU register and is acted on after the freeze.
      {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
    end else if (state_q == ST_REDIRECT) begin
      pc_redirect        = 1'b1;
      pc_redirect_target = pend_target;
      flush_if_id        = 1'b1;
      pend_clr           = 1'b1;
    end else if (branch_taken_ex) begin
      flush_if_id      = 1'b1;
      inject_nop_id_ex = 1'b1;
      if (block_pipe_instr_cache) begin
        en_pc    = 1'b0;
        pend_set = 1'b1;
      end else begin
        pc_redirect        = 1'b1;
        pc_redirect_target = branch_target_ex;
        pend_clr           = 1'b1;
      end
    end else if (lu) begin
      en_pc            = 1'b0;
      en_if_id         = 1'b0;
      inject_nop_id_ex = 1'b1;
    end else if (block_pipe_instr_cache) begin
      en_pc       = 1'b0;
      flush_if_id = 1'b1;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (block_pipe_data_cache)                              state_d = ST_DC_WAIT;
    else if (state_q == ST_REDIRECT)                        state_d = ST_RUN;
    else if (block_pipe_instr_cache)                        state_d = ST_IC_WAIT;
    else if (pend)                                          state_d = ST_REDIRECT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      pend        <= 1'b0;
      pend_target <= '0;
    end else begin
      state_q <= state_d;
      if (pend_set) begin
        pend        <= 1'b1;
        pend_target <= branch_target_ex;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
    end
  end

  pipe_stall_watchdog #(.STALL_TIMEOUT(STALL_TIMEOUT)) u_watchdog (
    .clk           (clk),
    .reset         (reset),
    .blocked       (block_pipe_data_cache | block_pipe_instr_cache),
    .stall_timeout (stall_timeout)
  );

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!en_pc && (stall_cycles != '1))      stall_cycles <= stall_cycles + 1'b1;
      if (pc_redirect && (flush_count != '1))  flush_count  <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [ADDR_W-1:0]  addrA_d = '0, addrB_d = '0, regD_ex = '0;
  logic               useA_d = 1'b0, useB_d = 1'b0, mem_r_en_ex = 1'b0;
  logic               branch_taken_ex = 1'b0;
  logic [VADDR_W-1:0] branch_target_ex = '0;
  logic               block_pipe_data_cache = 1'b0, block_pipe_instr_cache = 1'b0;
  logic               en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic               flush_if_id, inject_nop_id_ex, pc_redirect, stall_timeout;
  logic [VADDR_W-1:0] pc_redirect_target;
  logic [1:0]         state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]        stall_cycles, flush_count;
`endif
  logic [7:0]         ctl;
  int                 errors = 0;
  int                 checks = 0;

  always #5 clk = ~clk;

  assign ctl = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                flush_if_id, inject_nop_id_ex, pc_redirect};

  pipe_ctrl #(.STALL_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .addrA_d(addrA_d), .addrB_d(addrB_d), .useA_d(useA_d), .useB_d(useB_d),
    .regD_ex(regD_ex), .mem_r_en_ex(mem_r_en_ex),
    .branch_taken_ex(branch_taken_ex), .branch_target_ex(branch_target_ex),
    .block_pipe_data_cache(block_pipe_data_cache),
    .block_pipe_instr_cache(block_pipe_instr_cache),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
    .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .flush_if_id(flush_if_id), .inject_nop_id_ex(inject_nop_id_ex),
    .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
    .state(state),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .stall_timeout(stall_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    // ctl bits: en_pc en_if_id en_id_ex en_ex_mem en_mem_wb flush inject redirect
    settle();
    chk("rst_ctl", ctl, 8'b00000_110);
    chk("rst_tgt", pc_redirect_target, 0);
    chk("rst_state", state, 0);
    chk("rst_wdog", stall_timeout, 0);
    cyc(); cyc();
    reset = 1'b1;
    settle();
    chk("idle_ctl", ctl, 8'b11111_000);
    chk("idle_state", state, 0);

    // Load r5, decode reads r5 through port B
    mem_r_en_ex = 1'b1; regD_ex = 5; useB_d = 1'b1; addrB_d = 5;
    settle();
    chk("lu_b_ctl", ctl, 8'b00111_010);
    cyc();
    mem_r_en_ex = 1'b0;
    settle();
    chk("lu_after_ctl", ctl, 8'b11111_000);
    cyc();

    // Port A hazard, then the same register but useA_d low
    mem_r_en_ex = 1'b1; regD_ex = 3; useB_d = 1'b0; useA_d = 1'b1; addrA_d = 3;
    settle();
    chk("lu_a_ctl", ctl, 8'b00111_010);
    useA_d = 1'b0;
    settle();
    chk("lu_nouse_ctl", ctl, 8'b11111_000);
    cyc();

    // Register 0 load never stalls
    regD_ex = 0; useB_d = 1'b1; addrB_d = 0;
    settle();
    chk("r0_ctl", ctl, 8'b11111_000);
    cyc();
    mem_r_en_ex = 1'b0; useB_d = 1'b0;

    // D-freeze for 7 cycles with a taken branch held
    block_pipe_data_cache = 1'b1; branch_taken_ex = 1'b1; branch_target_ex = 32'h100;
    for (int i = 0; i < 7; i++) begin
      settle();
      chk($sformatf("dfz_ctl%0d", i), ctl, 8'b00000_000);
      chk($sformatf("dfz_state%0d", i), state, (i == 0) ? 0 : 1);
      cyc();
    end
    block_pipe_data_cache = 1'b0;
    settle();
    chk("dfz_exit_state", state, 1);
    chk("dfz_exit_ctl", ctl, 8'b11111_111);
    chk("dfz_exit_tgt", pc_redirect_target, 32'h100);
    chk("wdog_7_dc", stall_timeout, 0);
    cyc();
    branch_taken_ex = 1'b0;
    settle();
    chk("dfz_run_state", state, 0);
    chk("dfz_run_ctl", ctl, 8'b11111_000);
    cyc();

    // Deferred branch: I-cache busy for 3 cycles
    branch_taken_ex = 1'b1; branch_target_ex = 32'h40; block_pipe_instr_cache = 1'b1;
    settle();
    chk("def_br_ctl", ctl, 8'b01111_110);
    cyc();
    branch_taken_ex = 1'b0; branch_target_ex = 32'h999;
    for (int i = 1; i < 3; i++) begin
      settle();
      chk($sformatf("def_ic_ctl%0d", i), ctl, 8'b01111_100);
      chk($sformatf("def_ic_state%0d", i), state, 2);
      cyc();
    end
    block_pipe_instr_cache = 1'b0;
    settle();
    chk("def_fall_state", state, 2);
    chk("def_fall_ctl", ctl, 8'b11111_000);
    cyc();
    settle();
    chk("def_redir_state", state, 3);
    chk("def_redir_ctl", ctl, 8'b11111_101);
    chk("def_redir_tgt", pc_redirect_target, 32'h40);
    cyc();
    settle();
    chk("def_run_state", state, 0);
    chk("def_run_ctl", ctl, 8'b11111_000);
    cyc();

    // Load-use wins over I-busy; branch wins over load-use
    block_pipe_instr_cache = 1'b1; mem_r_en_ex = 1'b1; regD_ex = 7; useA_d = 1'b1; addrA_d = 7;
    settle();
    chk("lu_ic_ctl", ctl, 8'b00111_010);
    block_pipe_instr_cache = 1'b0; branch_taken_ex = 1'b1; branch_target_ex = 32'h80;
    settle();
    chk("br_lu_ctl", ctl, 8'b11111_111);
    chk("br_lu_tgt", pc_redirect_target, 32'h80);
    cyc();
    mem_r_en_ex = 1'b0; useA_d = 1'b0; branch_taken_ex = 1'b0;

    // Watchdog: 8 consecutive I-busy cycles set the sticky flag
    block_pipe_instr_cache = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    settle();
    chk("wdog_7", stall_timeout, 0);
    cyc();
    settle();
    chk("wdog_8", stall_timeout, 1);
    block_pipe_instr_cache = 1'b0;
    cyc(); cyc(); cyc();
    settle();
    chk("wdog_sticky", stall_timeout, 1);

    // Reset during REDIRECT discards the pending redirect
    branch_taken_ex = 1'b1; branch_target_ex = 32'h200; block_pipe_instr_cache = 1'b1;
    cyc();
    branch_taken_ex = 1'b0; block_pipe_instr_cache = 1'b0;
    cyc();
    settle();
    chk("rr_state", state, 3);
    reset = 1'b0;
    #1;
    chk("rr_rst_ctl", ctl, 8'b00000_110);
    chk("rr_rst_tgt", pc_redirect_target, 0);
    chk("rr_rst_state", state, 0);
    chk("rr_rst_wdog", stall_timeout, 0);
`ifdef PIPE_PERF_CNT_EN
    chk("rr_rst_stall_cnt", stall_cycles, 0);
    chk("rr_rst_flush_cnt", flush_count, 0);
`endif
    cyc();
    reset = 1'b1;
    settle();
    chk("rr_rel_ctl", ctl, 8'b11111_000);
    chk("rr_rel_state", state, 0);
    cyc();
    settle();
    chk("rr_rel2_ctl", ctl, 8'b11111_000);
    chk("rr_rel2_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

- Central stall/flush scheduler for the monocycle-derived 5-stage pipeline (fetch, decode, ALU, mem, writeback).
- Drives the write enables of the PC and every inter-stage register.
- Detects load-use hazards in decode and freezes or bubbles the pipe while either cache reports busy.
- Sequences branch redirects, including a redirect that arrives while the instruction cache is busy.

## Interface
Parameters:
- STALL_TIMEOUT, 1024: consecutive blocked cycles before `stall_timeout` sets.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- addrA_d, addrB_d  in  `ADDR_WIDTH`  source registers of the instruction in decode
- useA_d, useB_d  in  1  the instruction in decode reads addrA_d / addrB_d
- regD_ex  in  `ADDR_WIDTH`  destination register of the instruction in the ALU stage
- mem_r_en_ex  in  1  the instruction in the ALU stage is a load
- branch_taken_ex  in  1  taken branch resolved in the ALU stage
- branch_target_ex  in  `VIRT_ADDR_WIDTH`  its target
- block_pipe_data_cache  in  1  data cache busy
- block_pipe_instr_cache  in  1  instruction cache busy
- en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1  register write enables
- flush_if_id  out  1  fetch→decode register loads a NOP
- inject_nop_id_ex  out  1  decode→ALU register loads a NOP (decode stage `injecting_nop`)
- pc_redirect  out  1  PC loads pc_redirect_target
- pc_redirect_target  out  `VIRT_ADDR_WIDTH`  redirect address
- state  out  2  current FSM state
- stall_timeout  out  1  sticky watchdog flag
- stall_cycles, flush_count  out  32 each  performance counters (only with PIPE_PERF_CNT_EN)

## Operation
- Load-use hazard (LU) = mem_r_en_ex & regD_ex≠0 & ((useA_d & addrA_d==regD_ex) | (useB_d & addrB_d==regD_ex)).
- Register 0 never creates a hazard.
- Combinational rules, highest priority first. Any enable not named is 1. Any flush, inject or redirect signal not named is 0.
  - D-freeze, when block_pipe_data_cache=1:
    - All five enables are 0.
    - No flush or inject.
    - branch_taken_ex is ignored, since it stays held in the frozen ALU register.
  - Branch, when branch_taken_ex=1:
    - flush_if_id=1 and inject_nop_id_ex=1.
    - If block_pipe_instr_cache=0: pc_redirect=1 with pc_redirect_target=branch_target_ex.
    - If block_pipe_instr_cache=1: en_pc=0, and the target is latched into pend_target with the pend flag set.
  - LU: en_pc=0, en_if_id=0, inject_nop_id_ex=1. This applies whether or not the I-cache is busy.
  - I-busy, when block_pipe_instr_cache=1: en_pc=0, flush_if_id=1. Downstream stages drain.
- FSM states, with encodings in the shared header:
  - RUN: normal operation.
  - DC_WAIT: data cache blocking.
  - IC_WAIT: instruction cache blocking.
  - REDIRECT: issuing a deferred redirect.
- Transitions from RUN or IC_WAIT:
  - D-cache busy → DC_WAIT.
  - Otherwise I-cache busy → IC_WAIT.
  - Otherwise, if pend is set → REDIRECT.
  - Otherwise → RUN.
- DC_WAIT: leaves when D-cache is not busy, using the RUN rules.
- REDIRECT (exactly one cycle):
  - Outputs pc_redirect=1, target=pend_target, flush_if_id=1.
  - Clears pend.
  - Returns to RUN, or to DC_WAIT if the D-cache is busy; D-freeze still overrides.
- A second taken branch while pend is set overwrites pend_target; the younger branch is impossible after the flush, so the last one wins.
- Watchdog:
  - Counts consecutive cycles with either block input high; clears on any unblocked cycle.
  - When the count reaches STALL_TIMEOUT, stall_timeout sets and stays set until reset. The count saturates.

## Timing
- Hazard, freeze and flush outputs are combinational in the same cycle as their inputs. The downstream registers act on the next posedge.
- A load-use hazard costs exactly one bubble.
- A branch resolves with a 2-cycle penalty (IF/ID and ID/EX flushed).
- A deferred redirect issues in the first cycle after block_pipe_instr_cache falls.
- Reset (async assert, synchronous-safe deassert), outputs while reset=0:
  - State is RUN.
  - pend=0, pend_target=0.
  - Watchdog count 0, stall_timeout=0, counters 0.
  - All enables 0, flush_if_id=1, inject_nop_id_ex=1, pc_redirect=0, pc_redirect_target=0.
- Reset mid-stall or mid-pend discards the pending redirect.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with en_pc=0.
  - flush_count increments on every cycle with pc_redirect=1.
  - Both are 32-bit and saturate at all-ones.
- PIPE_PERF_CNT_EN undefined: the counter ports and their logic are absent.

## Structure
- Shared constants go in header.vh: `ADDR_WIDTH`, `VIRT_ADDR_WIDTH`, the 2-bit state encodings `PCTL_RUN`, `PCTL_DC_WAIT`, `PCTL_IC_WAIT`, `PCTL_REDIRECT`, and the NOP encoding.
- One sub-module: pipe_stall_watchdog (blocked-cycle counter plus sticky flag, parameter STALL_TIMEOUT).

## Test plan
- Load-use: load r5 in ALU stage, decode reads r5 via useB_d → one cycle with en_pc=0, en_if_id=0, inject_nop_id_ex=1, then all enables return to 1.
- Register 0: same as above with regD_ex=0 → no stall.
- D-freeze: block_pipe_data_cache high for 7 cycles, with branch_taken_ex=1 throughout → all enables 0 and state=DC_WAIT for 7 cycles; first unblocked cycle gives pc_redirect=1 with the branch target.
- Deferred branch: branch_taken_ex=1, target 0x40, with block_pipe_instr_cache=1 for 3 cycles → state IC_WAIT; then one REDIRECT cycle with pc_redirect_target=0x40 and flush_if_id=1; then RUN.
- Watchdog: STALL_TIMEOUT=8, I-cache blocked 8 cycles → stall_timeout=1 and it stays set after unblocking; a 7-cycle block does not set it.
- Reset: assert reset during REDIRECT → outputs take the reset values immediately; after release no redirect is issued. With PIPE_PERF_CNT_EN, the counters read 0.
